// File: rtl/lamp_pattern_decoder_if.sv
// Signal bundle between the lamp line source and the lamp pattern decoder.
// The master drives the lamp line and error clear; the slave returns status.
interface lamp_pattern_decoder_if #(
  parameter int CNT_W = 8
);

  logic             L;
  logic             CLR_ERR;
  logic [1:0]       MODE;
  logic [CNT_W-1:0] PERIOD;
  logic             PVALID;
  logic [CNT_W-1:0] EDGE_CNT;
  logic             JITTER;

  modport master (
    output L,
    output CLR_ERR,
    input  MODE,
    input  PERIOD,
    input  PVALID,
    input  EDGE_CNT,
    input  JITTER
  );

  modport slave (
    input  L,
    input  CLR_ERR,
    output MODE,
    output PERIOD,
    output PVALID,
    output EDGE_CNT,
    output JITTER
  );

endinterface

// File: rtl/lamp_pattern_decoder.sv
// Lamp line classifier: decodes OFF / ON / BLINK, measures the rise-to-rise
// period, counts rising edges and flags period changes while blinking.
module lamp_pattern_decoder #(
  parameter int CNT_W   = 8,
  parameter int TIMEOUT = 16
) (
  input  logic                  CLK,
  input  logic                  reset,
  lamp_pattern_decoder_if.slave bus
);

  typedef enum logic [1:0] {
    MODE_UNKNOWN = 2'b00,
    MODE_OFF     = 2'b01,
    MODE_ON      = 2'b10,
    MODE_BLINK   = 2'b11
  } mode_e;

  localparam logic [CNT_W-1:0] CNT_ZERO   = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] QUIET_MAX  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] QUIET_LAST = CNT_W'(TIMEOUT - 1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] val,
                                               input logic [CNT_W-1:0] lim);
    logic [CNT_W-1:0] res;
    if (val >= lim) begin
      res = lim;
    end else begin
      res = val + CNT_ONE;
    end
    return res;
  endfunction

  mode_e            mode_r;
  mode_e            mode_nxt_s;
  logic             l_q_r;
  logic [CNT_W-1:0] pcnt_r;
  logic [CNT_W-1:0] quiet_r;
  logic             have_ref_r;
  logic [CNT_W-1:0] period_r;
  logic             pvalid_r;
  logic [CNT_W-1:0] edge_cnt_r;
  logic             jitter_r;

  logic             rise_s;
  logic             fall_s;
  logic             edge_s;
  logic             timeout_s;
  logic             jitter_set_s;
  logic [CNT_W-1:0] pcnt_nxt_s;
  logic [CNT_W-1:0] quiet_nxt_s;
  logic             have_ref_nxt_s;
  logic [CNT_W-1:0] period_nxt_s;
  logic             pvalid_nxt_s;
  logic [CNT_W-1:0] edge_cnt_nxt_s;
  logic             jitter_nxt_s;

  // l_q_r resets to 0, so a high lamp on the first sample is seen as a rise
  assign rise_s    = bus.L & ~l_q_r;
  assign fall_s    = ~bus.L & l_q_r;
  assign edge_s    = rise_s | fall_s;
  assign timeout_s = ~edge_s & (quiet_r == QUIET_LAST);

  // Mode next-state: settle on quiet timeout, enter BLINK on a referenced rise
  always_comb begin
    mode_nxt_s = mode_r;
    case (mode_r)
      MODE_UNKNOWN: begin
        if (timeout_s) begin
          mode_nxt_s = bus.L ? MODE_ON : MODE_OFF;
        end else if (rise_s & have_ref_r) begin
          mode_nxt_s = MODE_BLINK;
        end else begin
          mode_nxt_s = mode_r;
        end
      end
      MODE_OFF, MODE_ON: begin
        if (edge_s) begin
          mode_nxt_s = MODE_UNKNOWN;
        end else begin
          mode_nxt_s = mode_r;
        end
      end
      MODE_BLINK: begin
        if (timeout_s) begin
          mode_nxt_s = bus.L ? MODE_ON : MODE_OFF;
        end else begin
          mode_nxt_s = mode_r;
        end
      end
      default: begin
        mode_nxt_s = MODE_UNKNOWN;
      end
    endcase
  end

  // Mode state register
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      mode_r <= MODE_UNKNOWN;
    end else begin
      mode_r <= mode_nxt_s;
    end
  end

  // Datapath next values: period counter, quiet counter, edge count, jitter
  always_comb begin
    pcnt_nxt_s     = pcnt_r;
    quiet_nxt_s    = quiet_r;
    have_ref_nxt_s = have_ref_r;
    period_nxt_s   = period_r;
    pvalid_nxt_s   = 1'b0;
    edge_cnt_nxt_s = edge_cnt_r;
    jitter_nxt_s   = jitter_r;
    jitter_set_s   = 1'b0;

    if (rise_s) begin
      pcnt_nxt_s = CNT_ONE;
    end else begin
      pcnt_nxt_s = sat_inc(pcnt_r, CNT_MAX);
    end

    if (edge_s) begin
      quiet_nxt_s = CNT_ZERO;
    end else begin
      quiet_nxt_s = sat_inc(quiet_r, QUIET_MAX);
    end

    // A timeout means the reference rise is too old to measure against
    if (rise_s) begin
      have_ref_nxt_s = 1'b1;
    end else if (timeout_s) begin
      have_ref_nxt_s = 1'b0;
    end else begin
      have_ref_nxt_s = have_ref_r;
    end

    if (rise_s & have_ref_r) begin
      period_nxt_s = pcnt_r;
      pvalid_nxt_s = 1'b1;
    end else begin
      period_nxt_s = period_r;
      pvalid_nxt_s = 1'b0;
    end

    if (rise_s) begin
      edge_cnt_nxt_s = edge_cnt_r + CNT_ONE;
    end else begin
      edge_cnt_nxt_s = edge_cnt_r;
    end

    // Only rises inside BLINK compare; the BLINK-entry period is the reference
    jitter_set_s = (mode_r == MODE_BLINK) & rise_s & have_ref_r & (pcnt_r != period_r);
    if (jitter_set_s) begin
      jitter_nxt_s = 1'b1;
    end else if (bus.CLR_ERR) begin
      jitter_nxt_s = 1'b0;
    end else begin
      jitter_nxt_s = jitter_r;
    end
  end

  // Datapath and status registers
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      l_q_r      <= 1'b0;
      pcnt_r     <= CNT_ZERO;
      quiet_r    <= CNT_ZERO;
      have_ref_r <= 1'b0;
      period_r   <= CNT_ZERO;
      pvalid_r   <= 1'b0;
      edge_cnt_r <= CNT_ZERO;
      jitter_r   <= 1'b0;
    end else begin
      l_q_r      <= bus.L;
      pcnt_r     <= pcnt_nxt_s;
      quiet_r    <= quiet_nxt_s;
      have_ref_r <= have_ref_nxt_s;
      period_r   <= period_nxt_s;
      pvalid_r   <= pvalid_nxt_s;
      edge_cnt_r <= edge_cnt_nxt_s;
      jitter_r   <= jitter_nxt_s;
    end
  end

  assign bus.MODE     = mode_r;
  assign bus.PERIOD   = period_r;
  assign bus.PVALID   = pvalid_r;
  assign bus.EDGE_CNT = edge_cnt_r;
  assign bus.JITTER   = jitter_r;

endmodule
